// File: rtl/and_gate.sv
// Pipelined bitwise AND of two operands with valid/ready flow control and result flags.
// Define AND_GATE_STATS_EN to add the saturating hit_count output (transfers with f_all=1).
module and_gate #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [WIDTH-1:0]             A,
    input  logic [WIDTH-1:0]             B,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [WIDTH-1:0]             F,
    output logic                         f_all,
    output logic                         f_none,
    output logic [$clog2(WIDTH+1)-1:0]   f_ones,
    output logic                         out_valid,
    input  logic                         out_ready
`ifdef AND_GATE_STATS_EN
    ,
    output logic [15:0]                  hit_count
`endif
);

    localparam int CW = $clog2(WIDTH + 1);

    // Handshake: a side transfers on a rising edge where its valid and ready are both 1.
    // The whole pipeline advances in lockstep whenever the output slot is free or being drained.
    logic              advance;
    logic [STAGES-1:0] valid_q;

    assign out_valid = valid_q[STAGES-1];
    assign in_ready  = !out_valid || out_ready;
    assign advance   = in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else if (advance) begin
            for (int i = STAGES - 1; i > 0; i--) begin
                valid_q[i] <= valid_q[i-1];
            end
            valid_q[0] <= in_valid;
        end
    end

    // Data registers load only when a valid item moves in; bubbles leave them untouched.
    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        logic [WIDTH-1:0] q;
        logic [WIDTH-1:0] nxt;
        logic             load;

        if (s == 0) begin : g_first
            assign nxt  = A & B;
            assign load = in_valid;
        end else begin : g_next
            assign nxt  = g_stage[s-1].q;
            assign load = valid_q[s-1];
        end

        if (s == STAGES - 1) begin : g_last
            // The output register is cleared so F reads zero while reset is held.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    q <= '0;
                end else if (advance && load) begin
                    q <= nxt;
                end
            end
        end else begin : g_mid
            always_ff @(posedge clk) begin
                if (advance && load) begin
                    q <= nxt;
                end
            end
        end
    end

    assign F      = g_stage[STAGES-1].q;
    assign f_all  = &F;
    assign f_none = ~|F;

    always_comb begin
        f_ones = '0;
        for (int i = 0; i < WIDTH; i++) begin
            f_ones = f_ones + CW'(F[i]);
        end
    end

`ifdef AND_GATE_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_count <= '0;
        end else if (out_valid && out_ready && f_all && (hit_count != 16'hFFFF)) begin
            hit_count <= hit_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_and_gate.sv
// Self-checking bench for and_gate: a timestamp-queue reference model checked every cycle,
// plus directed literal checks for truth table, flags, backpressure, reset and statistics.
module tb_and_gate;

    localparam int W   = 8;
    localparam int STG = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] A, B;
    logic         in_valid, in_ready, out_valid, out_ready;
    logic [W-1:0] F;
    logic         f_all, f_none;
    logic [3:0]   f_ones;

    logic tt_a, tt_b, tt_iv, tt_ir, tt_f, tt_all, tt_none, tt_ones, tt_ov, tt_or;

`ifdef AND_GATE_STATS_EN
    logic [15:0] hit_count, tt_hits;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    and_gate #(.WIDTH(W), .STAGES(STG)) dut (
        .clk(clk), .rst(rst), .A(A), .B(B), .in_valid(in_valid), .in_ready(in_ready),
        .F(F), .f_all(f_all), .f_none(f_none), .f_ones(f_ones),
        .out_valid(out_valid), .out_ready(out_ready)
`ifdef AND_GATE_STATS_EN
        , .hit_count(hit_count)
`endif
    );

    and_gate #(.WIDTH(1), .STAGES(1)) u_tt (
        .clk(clk), .rst(rst), .A(tt_a), .B(tt_b), .in_valid(tt_iv), .in_ready(tt_ir),
        .F(tt_f), .f_all(tt_all), .f_none(tt_none), .f_ones(tt_ones),
        .out_valid(tt_ov), .out_ready(tt_or)
`ifdef AND_GATE_STATS_EN
        , .hit_count(tt_hits)
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: each accepted operand is stamped with the index of the advancing edge
    // that took it; it is on the output once STG-1 further advancing edges have occurred.
    logic [W-1:0] exp_q[$];
    int           idx_q[$];
    int           adv_cnt = 0;
    logic [W-1:0] last_f  = '0;
    logic [15:0]  m_hits  = '0;
    logic         m_cur;

    function automatic logic model_valid();
        return (exp_q.size() > 0) && (idx_q[0] + STG - 1 == adv_cnt);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_q.delete();
            idx_q.delete();
            last_f = '0;
            m_hits = '0;
        end else begin
            m_cur = model_valid();
            if (!m_cur || out_ready) begin
                if (m_cur) begin
                    last_f = exp_q[0];
                    if (exp_q[0] == {W{1'b1}} && m_hits != 16'hFFFF) m_hits = m_hits + 16'd1;
                    void'(exp_q.pop_front());
                    void'(idx_q.pop_front());
                end
                adv_cnt++;
                if (in_valid) begin
                    exp_q.push_back(A & B);
                    idx_q.push_back(adv_cnt);
                end
            end
        end
    end

    always @(negedge clk) begin
        logic         ev;
        logic [W-1:0] ef;
        ev = model_valid();
        ef = ev ? exp_q[0] : last_f;
        check("out_valid", out_valid, ev);
        check("in_ready", in_ready, !ev || out_ready);
        check("F", F, ef);
        check("f_all", f_all, ef == {W{1'b1}});
        check("f_none", f_none, ef == '0);
        check("f_ones", f_ones, $countones(ef));
`ifdef AND_GATE_STATS_EN
        check("hit_count", hit_count, m_hits);
`endif
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Holds the operand until an edge where the block was ready; returns 1ns after that edge.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
        logic rdy;
        int   waited;
        A = a;
        B = b;
        in_valid = 1'b1;
        waited = 0;
        forever begin
            @(negedge clk);
            rdy = in_ready;
            tick();
            if (rdy) break;
            waited++;
            if (waited > 50) begin
                n_tests++;
                n_fail++;
                $display("FAIL send_timeout actual=stalled required=accepted at %0t", $time);
                break;
            end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic tt_exp[4];
        logic [1:0] ab;
        tt_exp = '{1'b0, 1'b0, 1'b0, 1'b1};

        rst = 1'b1;
        A = '0; B = '0; in_valid = 1'b0; out_ready = 1'b1;
        tt_a = 1'b0; tt_b = 1'b0; tt_iv = 1'b0; tt_or = 1'b1;
        repeat (2) tick();
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_F", F, 8'h00);
        check("rst_f_all", f_all, 1'b0);
        check("rst_f_none", f_none, 1'b1);
        check("rst_f_ones", f_ones, 4'd0);
        check("rst_in_ready", in_ready, 1'b1);

        // First operand presented as reset releases must be taken on the very next edge.
        rst = 1'b0;
        A = 8'hF0; B = 8'h3C; in_valid = 1'b1;
        tick();
        A = 8'hFF; B = 8'hFF;
        tick();
        in_valid = 1'b0;
        tick();
        check("wide_valid", out_valid, 1'b1);
        check("wide_F", F, 8'h30);
        check("wide_ones", f_ones, 4'd2);
        check("wide_all", f_all, 1'b0);
        check("wide_none", f_none, 1'b0);
        tick();
        check("ones_F", F, 8'hFF);
        check("ones_all", f_all, 1'b1);
        check("ones_cnt", f_ones, 4'd8);
        tick();
        check("hold_F_after_drain", F, 8'hFF);

        tt_iv = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ab = 2'(i);
            tt_a = ab[1];
            tt_b = ab[0];
            tick();
            check("tt_valid", tt_ov, 1'b1);
            check($sformatf("tt_F_%0d%0d", ab[1], ab[0]), tt_f, tt_exp[i]);
        end
        tt_iv = 1'b0;
        tick();
        check("tt_idle", tt_ov, 1'b0);

        fork
            begin
                send(8'hA5, 8'h0F);
                send(8'h3C, 8'hF3);
                send(8'hFF, 8'h81);
                send(8'h77, 8'hEE);
                in_valid = 1'b0;
            end
            begin
                out_ready = 1'b0;
                repeat (3) tick();
                check("bp_valid", out_valid, 1'b1);
                check("bp_F0", F, 8'h05);
                tick();
                check("bp_in_ready", in_ready, 1'b0);
                check("bp_F1", F, 8'h05);
                tick();
                check("bp_F2", F, 8'h05);
                check("bp_valid2", out_valid, 1'b1);
                out_ready = 1'b1;
            end
        join
        repeat (6) tick();

        for (int i = 0; i < 400; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            A         = W'($urandom);
            B         = ($urandom_range(0, 3) == 0) ? {W{1'b1}} : W'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (6) tick();

        // Reset pulse strictly between clock edges with results in flight.
        send(8'h12, 8'h34);
        send(8'h56, 8'h78);
        in_valid = 1'b0;
        tick();
        check("mid_valid_before", out_valid, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("mid_valid_async", out_valid, 1'b0);
        check("mid_F_async", F, 8'h00);
        check("mid_in_ready", in_ready, 1'b1);
        #1 rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("mid_no_result", out_valid, 1'b0);
        end

`ifdef AND_GATE_STATS_EN
        check("stats_rst", hit_count, 16'd0);
        send(8'hFF, 8'hFF);
        send(8'h0F, 8'hFF);
        send(8'hFF, 8'hFF);
        send(8'h00, 8'h00);
        send(8'hFF, 8'hFF);
        in_valid = 1'b0;
        repeat (5) tick();
        check("stats_three", hit_count, 16'd3);
        A = 8'hFF; B = 8'hFF; in_valid = 1'b1;
        repeat (65540) tick();
        in_valid = 1'b0;
        repeat (5) tick();
        check("stats_saturate", hit_count, 16'hFFFF);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
